// File: rtl/spi_ahb_pkg.sv
// Shared definitions for the AHB SPI master: register offsets, STATUS bit
// positions and the shift-engine state encoding.
package spi_ahb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CS     = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Single-byte SPI mode-0 shift engine, MSB first: divider, edge counter,
// tx/rx shift registers and the SCLK/MOSI outputs.
module spi_shift_engine
    import spi_ahb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic [7:0] div_i,
    input  logic       miso_i,
    output logic       busy_o,
    output logic       done_pulse_o,
    output logic [7:0] rx_byte_o,
    output logic       sclk_o,
    output logic       mosi_o
);

    spi_state_e state_q, state_d;
    logic [7:0] div_lat_q;
    logic [7:0] div_cnt_q;
    logic [3:0] edge_cnt_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       edge_tick;
    logic       last_edge;

    assign edge_tick = (state_q == ST_SHIFT) && (div_cnt_q == div_lat_q);
    assign last_edge = edge_tick && (edge_cnt_q == 4'd15);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (last_edge) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        done_pulse_o = (state_q == ST_DONE);
    end

    // The divider is captured at start so DIV writes mid-transfer only affect the next byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_lat_q  <= '0;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sclk_q <= 1'b0;
                    if (start_i) begin
                        tx_q      <= tx_byte_i;
                        div_lat_q <= div_i;
                    end
                end
                ST_LOAD: begin
                    mosi_q     <= tx_q[7];
                    div_cnt_q  <= '0;
                    edge_cnt_q <= '0;
                    sclk_q     <= 1'b0;
                end
                ST_SHIFT: begin
                    if (edge_tick) begin
                        div_cnt_q  <= '0;
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + 4'd1;
                        if (!sclk_q) begin
                            rx_q <= {rx_q[6:0], miso_i};
                        end else if (edge_cnt_q != 4'd15) begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            mosi_q <= tx_q[6];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                default: sclk_q <= 1'b0;
            endcase
        end
    end

    assign rx_byte_o = rx_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;

endmodule

// File: rtl/ahb_spi_master.sv
// AHB-Lite slave front end for the SPI shift engine: address-phase capture,
// register file (DATA/STATUS/DIV/CS) and registered read data.
module ahb_spi_master
    import spi_ahb_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'h03,
    parameter logic       CS_RESET  = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        SPI_SCLK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SPI_CS_N
);

    logic        accept;
    logic        data_rd;
    logic        start;
    logic        busy;
    logic        done_pulse;
    logic [7:0]  rx_byte;
    logic        wr_q;
    logic [1:0]  addr_q;
    logic [31:0] hrdata_q;
    logic [31:0] rd_mux;
    logic [7:0]  rxdata_q;
    logic        done_q;
    logic [7:0]  div_q;
    logic        cs_q;
    logic        unused_bits;

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign data_rd = accept & ~HWRITE & (HADDR[3:2] == REG_DATA);
    assign start   = wr_q & (addr_q == REG_DATA) & ~busy;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

    always_comb begin
        rd_mux = '0;
        unique case (HADDR[3:2])
            REG_DATA:   rd_mux[7:0] = rxdata_q;
            REG_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done_q;
            end
            REG_DIV:    rd_mux[7:0] = div_q;
            default:    rd_mux[0]   = cs_q;
        endcase
    end

    // Completion has priority over a same-cycle DATA read clearing done.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            hrdata_q <= '0;
            rxdata_q <= '0;
            done_q   <= 1'b0;
            div_q    <= DIV_RESET;
            cs_q     <= CS_RESET;
        end else begin
            wr_q   <= accept & HWRITE;
            addr_q <= HADDR[3:2];
            if (accept && !HWRITE) hrdata_q <= rd_mux;
            if (done_pulse) begin
                rxdata_q <= rx_byte;
                done_q   <= 1'b1;
            end else if (start || data_rd) begin
                done_q <= 1'b0;
            end
            if (wr_q && addr_q == REG_DIV) div_q <= HWDATA[7:0];
            if (wr_q && addr_q == REG_CS)  cs_q  <= HWDATA[0];
        end
    end

    spi_shift_engine u_eng (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .start_i      (start),
        .tx_byte_i    (HWDATA[7:0]),
        .div_i        (div_q),
        .miso_i       (SPI_MISO),
        .busy_o       (busy),
        .done_pulse_o (done_pulse),
        .rx_byte_o    (rx_byte),
        .sclk_o       (SPI_SCLK),
        .mosi_o       (SPI_MOSI)
    );

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign SPI_CS_N  = cs_q;

endmodule

// File: tb/tb_ahb_spi_master.sv
// Directed bench for ahb_spi_master: register vector table plus loopback
// transfer, write-while-busy and reset-mid-transfer sequences.
module tb_ahb_spi_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        SPI_SCLK;
    logic        SPI_MOSI;
    logic        SPI_MISO;
    logic        SPI_CS_N;

    int checks = 0;
    int errors = 0;

    int          pulses;
    int          sclk_edges;
    logic [7:0]  mosi_sh;
    time         last_rise;
    time         period;

    always #5 HCLK = ~HCLK;

    assign SPI_MISO = SPI_MOSI;

    ahb_spi_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .SPI_SCLK  (SPI_SCLK),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO),
        .SPI_CS_N  (SPI_CS_N)
    );

    always @(posedge SPI_SCLK) begin
        if (pulses > 0) period = $time - last_rise;
        last_rise = $time;
        pulses    = pulses + 1;
        mosi_sh   = {mosi_sh[6:0], SPI_MOSI};
    end

    always @(SPI_SCLK) sclk_edges = sclk_edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        pulses     = 0;
        sclk_edges = 0;
        mosi_sh    = 8'h00;
        period     = 0;
        last_rise  = 0;
    endtask

    // Tasks start and end 1ns after a rising HCLK edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic wait_idle(output int n, output logic [31:0] st);
        n = 0;
        st = '0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
        for (int i = 0; i < 6000; i++) begin
            @(posedge HCLK); #1;
            st = HRDATA;
            if (!st[0]) break;
            n++;
        end
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic do_xfer(input logic [7:0] div, input logic [7:0] tx);
        int          n;
        logic [31:0] st;
        logic [31:0] rd;
        bus_write(32'h8, {24'h0, div});
        clr_mon();
        bus_write(32'h0, {24'h0, tx});
        wait_idle(n, st);
        chk("busy_cycles", n, 2 + 16 * (int'(div) + 1));
        chk("status_done", st, 32'h2);
        chk("sclk_pulses", pulses, 8);
        chk("mosi_bits", {24'h0, mosi_sh}, {24'h0, tx});
        chk("sclk_period", period, 20 * (int'(div) + 1));
        bus_read(32'h0, rd);
        chk("rx_data", rd, {24'h0, tx});
        bus_read(32'h4, rd);
        chk("status_clr", rd, 32'h0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        exp_cs;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd;
        int          n;
        logic [31:0] st;

        vecs[0]  = '{0, 32'h4, 32'h0,   32'h0,  1'b1};
        vecs[1]  = '{0, 32'h8, 32'h0,   32'h3,  1'b1};
        vecs[2]  = '{0, 32'h0, 32'h0,   32'h0,  1'b1};
        vecs[3]  = '{0, 32'hC, 32'h0,   32'h1,  1'b1};
        vecs[4]  = '{1, 32'h8, 32'h1FF, 32'h0,  1'b1};
        vecs[5]  = '{0, 32'h8, 32'h0,   32'hFF, 1'b1};
        vecs[6]  = '{1, 32'h4, 32'h3,   32'h0,  1'b1};
        vecs[7]  = '{0, 32'h4, 32'h0,   32'h0,  1'b1};
        vecs[8]  = '{1, 32'hC, 32'h0,   32'h0,  1'b0};
        vecs[9]  = '{0, 32'hC, 32'h0,   32'h0,  1'b0};
        vecs[10] = '{1, 32'hC, 32'h1,   32'h0,  1'b1};
        vecs[11] = '{0, 32'hC, 32'h0,   32'h1,  1'b1};

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00;
        HWRITE = 1'b0; HREADY = 1'b1; HWDATA = '0;
        clr_mon();
        repeat (10) @(posedge HCLK);
        #1;
        chk("rst_sclk", {31'h0, SPI_SCLK}, 32'h0);
        chk("rst_mosi", {31'h0, SPI_MOSI}, 32'h0);
        chk("rst_cs_n", {31'h0, SPI_CS_N}, 32'h1);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("hresp", {31'h0, HRESP}, 32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
            chk($sformatf("vec%0d_cs_n", i), {31'h0, SPI_CS_N}, {31'h0, vecs[i].exp_cs});
        end

        do_xfer(8'h00, 8'hA5);
        do_xfer(8'h03, 8'h3C);
        do_xfer(8'hFF, 8'hC3);

        // CS held low across a transfer is untouched by the engine.
        bus_write(32'hC, 32'h0);
        chk("cs_low", {31'h0, SPI_CS_N}, 32'h0);
        do_xfer(8'h01, 8'h69);
        chk("cs_low_after", {31'h0, SPI_CS_N}, 32'h0);
        bus_write(32'hC, 32'h1);
        chk("cs_high", {31'h0, SPI_CS_N}, 32'h1);

        // Back-to-back DATA writes: the second lands while busy.
        bus_write(32'h8, 32'h0);
        clr_mon();
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HWDATA = 32'h11;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFF;
        @(posedge HCLK); #1;
        wait_idle(n, st);
        chk("wwb_busy_cycles", n, 17);
        chk("wwb_status", st, 32'h2);
        bus_read(32'h0, rd);
        chk("wwb_rx", rd, 32'h11);
        repeat (40) @(posedge HCLK);
        #1;
        chk("wwb_pulses", pulses, 8);

        // Reset in the middle of a transfer.
        clr_mon();
        bus_write(32'h0, 32'h96);
        for (int i = 0; i < 200; i++) begin
            if (sclk_edges >= 5) break;
            @(posedge HCLK); #1;
        end
        chk("mid_edges", sclk_edges, 5);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_sclk", {31'h0, SPI_SCLK}, 32'h0);
        chk("mid_rst_mosi", {31'h0, SPI_MOSI}, 32'h0);
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        bus_read(32'h4, rd);
        chk("mid_status", rd, 32'h0);
        bus_read(32'h0, rd);
        chk("mid_data", rd, 32'h0);
        bus_read(32'h8, rd);
        chk("mid_div", rd, 32'h3);
        do_xfer(8'h03, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
